// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, token-to-control mapping and
// the alignment FSM state type.
package tmds_pkg;

    localparam logic [9:0] TOK_00 = 10'h354;
    localparam logic [9:0] TOK_01 = 10'h0AB;
    localparam logic [9:0] TOK_10 = 10'h154;
    localparam logic [9:0] TOK_11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic is_token(input logic [9:0] w);
        return (w == TOK_00) || (w == TOK_01) || (w == TOK_10) || (w == TOK_11);
    endfunction

    // Non-token words map to 00; callers qualify with is_token.
    function automatic logic [1:0] token_ctrl(input logic [9:0] w);
        case (w)
            TOK_01:  return 2'b01;
            TOK_10:  return 2'b10;
            TOK_11:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Deserializer-side input and decoded-word output bundle of one TMDS channel.
// raw_valid_in qualifies raw_in for one cycle; there is no backpressure, and
// valid_out qualifies data_out/control_out/ve_out for exactly one cycle.
interface tmds_channel_decoder_if;
    import tmds_pkg::*;

    logic [9:0] raw_in;
    logic       raw_valid_in;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       valid_out;
    logic       locked_out;
    logic [3:0] rot_out;
    logic       err_out;
    state_t     state_dbg;

    modport master (
        output raw_in, raw_valid_in,
        input  data_out, control_out, ve_out, valid_out, locked_out, rot_out, err_out, state_dbg
    );

    modport slave (
        input  raw_in, raw_valid_in,
        output data_out, control_out, ve_out, valid_out, locked_out, rot_out, err_out, state_dbg
    );

endinterface

// File: rtl/tmds_word_decode.sv
// Combinational decode of one aligned TMDS word: pixel byte, token detect,
// control value and encoder-rule violation flag.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_word,
    output logic [7:0] o_byte,
    output logic       o_is_token,
    output logic [1:0] o_control,
    output logic       o_code_err
);

    logic [7:0] w_d;
    logic [7:0] w_out;
    logic [3:0] w_ones;
    logic       w_use_xnor;

    always_comb begin
        w_d      = i_word[9] ? ~i_word[7:0] : i_word[7:0];
        w_out    = '0;
        w_out[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_out[i] = i_word[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
        w_ones = '0;
        for (int i = 0; i < 8; i++) begin
            w_ones = w_ones + {3'b000, w_out[i]};
        end
        // The encoder picks XNOR (bit 8 = 0) for dense bytes; anything else is corrupt.
        w_use_xnor = (w_ones > 4'd4) || ((w_ones == 4'd4) && !w_out[0]);
    end

    assign o_byte     = w_out;
    assign o_is_token = is_token(i_word);
    assign o_control  = token_ctrl(i_word);
    assign o_code_err = !o_is_token && (i_word[8] == w_use_xnor);

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel word aligner and decoder: hunts control tokens across all 10
// rotations, confirms and holds lock, decodes data/control words.
// Optional TMDS_DEC_ERR_EN adds invalid-code detection that can also drop lock.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int GAP_LIMIT  = 4096,
    parameter int ERR_LIMIT  = 4
) (
    input logic                   clk_in,
    input logic                   rst_n_in,
    tmds_channel_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int GAP_W = $clog2(GAP_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_COUNT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);

    logic [9:0]       r_prev;
    state_t           r_state, w_state_nxt;
    logic [3:0]       r_rot, w_rot_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic [7:0]       r_data;
    logic [1:0]       r_control;
    logic             r_ve, r_valid, r_err;

    logic [19:0] w_window;
    logic [9:0]  w_word;
    logic        w_hunt_hit;
    logic [3:0]  w_hunt_rot;
    logic        w_emit, w_drop, w_err, w_err_drop;
    logic [7:0]  w_byte;
    logic        w_is_token;
    logic [1:0]  w_control;
    logic        w_code_err;

    assign w_window = {bus.raw_in, r_prev};

    // Descending scan so the lowest matching rotation is the one kept.
    always_comb begin
        w_word     = w_window[9:0];
        w_hunt_hit = 1'b0;
        w_hunt_rot = '0;
        for (int r = 9; r >= 0; r--) begin
            if (4'(r) == r_rot) w_word = w_window[r +: 10];
            if (is_token(w_window[r +: 10])) begin
                w_hunt_hit = 1'b1;
                w_hunt_rot = 4'(r);
            end
        end
    end

    tmds_word_decode u_decode (
        .i_word     (w_word),
        .o_byte     (w_byte),
        .o_is_token (w_is_token),
        .o_control  (w_control),
        .o_code_err (w_code_err)
    );

`ifdef TMDS_DEC_ERR_EN
    localparam int ERR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;

    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        w_err         = 1'b0;
        w_err_drop    = 1'b0;
        if (r_state != ST_LOCKED) begin
            w_err_cnt_nxt = '0;
        end else if (bus.raw_valid_in) begin
            if (w_code_err) begin
                w_err = 1'b1;
                if (r_err_cnt == ERR_LAST) begin
                    w_err_drop    = 1'b1;
                    w_err_cnt_nxt = '0;
                end else begin
                    w_err_cnt_nxt = r_err_cnt + 1'b1;
                end
            end else begin
                w_err_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_err_cnt <= '0;
        else           r_err_cnt <= w_err_cnt_nxt;
    end
`else
    logic w_unused_err;
    assign w_unused_err = w_code_err & (ERR_LIMIT > 0);
    assign w_err        = 1'b0;
    assign w_err_drop   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rot_nxt   = r_rot;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_emit      = 1'b0;
        w_drop      = 1'b0;
        if (bus.raw_valid_in) begin
            unique case (r_state)
                ST_HUNT: begin
                    if (w_hunt_hit) begin
                        w_rot_nxt   = w_hunt_rot;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (!w_is_token) begin
                        w_state_nxt = ST_HUNT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_LOCKED;
                        w_cnt_nxt   = CNT_W'(LOCK_COUNT);
                        w_gap_nxt   = '0;
                        w_emit      = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_is_token)            w_gap_nxt = '0;
                    else if (r_gap == GAP_LAST) w_drop   = 1'b1;
                    else                        w_gap_nxt = r_gap + 1'b1;
                    if (w_drop || w_err_drop) begin
                        w_state_nxt = ST_HUNT;
                        w_cnt_nxt   = '0;
                        w_gap_nxt   = '0;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_prev    <= '0;
            r_state   <= ST_HUNT;
            r_rot     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_data    <= '0;
            r_control <= '0;
            r_ve      <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (bus.raw_valid_in) r_prev <= bus.raw_in;
            r_state <= w_state_nxt;
            r_rot   <= w_rot_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_valid <= w_emit;
            r_err   <= w_err;
            if (w_emit) begin
                r_ve <= !w_is_token;
                if (w_is_token) begin
                    r_control <= w_control;
                    r_data    <= '0;
                end else begin
                    r_data <= w_byte;
                end
            end
        end
    end

    assign bus.data_out    = r_data;
    assign bus.control_out = r_control;
    assign bus.ve_out      = r_ve;
    assign bus.valid_out   = r_valid;
    assign bus.locked_out  = (r_state == ST_LOCKED);
    assign bus.rot_out     = r_rot;
    assign bus.err_out     = r_err;
    assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: directed scenarios plus randomized skewed
// streams, checked cycle by cycle against a behavioural model.
module tb_tmds_channel_decoder;
    import tmds_pkg::*;

    localparam int LOCK_COUNT = 16;
    localparam int GAP_LIMIT  = 4096;
    localparam int ERR_LIMIT  = 4;
    localparam int M_HUNT     = 0;
    localparam int M_CONFIRM  = 1;
    localparam int M_LOCKED   = 2;

    // ---------------- clock / reset ----------------
    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .LOCK_COUNT (LOCK_COUNT),
        .GAP_LIMIT  (GAP_LIMIT),
        .ERR_LIMIT  (ERR_LIMIT)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] dut_vec();
        return {bus.valid_out, bus.locked_out, bus.ve_out, bus.control_out,
                bus.data_out, bus.err_out, bus.rot_out};
    endfunction

    // ---------------- reference model ----------------
    int         m_mode, m_rot, m_tokens, m_gap, m_errs;
    logic [9:0] m_prev;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    logic       m_ve, m_valid, m_err;
    logic [9:0] g_prev;
    logic [9:0] tok_tab[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    function automatic int token_code(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] b;
        q    = w[9] ? ~w[7:0] : w[7:0];
        b    = '0;
        b[0] = q[0];
        for (int i = 1; i < 8; i++) b[i] = w[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
        return b;
    endfunction

    function automatic logic [9:0] ref_encode(input logic [7:0] d, input logic inv);
        logic [7:0] q;
        int         ones;
        logic       use_xnor;
        ones     = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? !(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        return {inv, !use_xnor, inv ? ~q : q};
    endfunction

    // A word is a legal data code exactly when re-encoding its decoded byte reproduces it.
    function automatic logic ref_bad(input logic [9:0] w);
        return ref_encode(ref_decode(w), w[9]) != w;
    endfunction

    task automatic model_reset();
        m_mode = M_HUNT; m_rot = 0; m_tokens = 0; m_gap = 0; m_errs = 0;
        m_prev = '0; m_data = '0; m_ctrl = '0; m_ve = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic emit(input logic [9:0] w, input int tc);
        m_valid = 1'b1;
        if (tc >= 0) begin
            m_ve = 1'b0; m_ctrl = 2'(tc); m_data = '0;
        end else begin
            m_ve = 1'b1; m_data = ref_decode(w);
        end
    endtask

    task automatic model_step(input logic [9:0] raw, input logic valid);
        logic [19:0] win;
        logic [9:0]  w;
        int          tc;
        bit          drop;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!valid) return;
        win    = {raw, m_prev};
        m_prev = raw;
        if (m_mode == M_HUNT) begin
            for (int r = 0; r < 10; r++) begin
                if (token_code(10'(win >> r)) >= 0) begin
                    m_rot = r; m_tokens = 1; m_mode = M_CONFIRM;
                    break;
                end
            end
        end else begin
            w  = 10'(win >> m_rot);
            tc = token_code(w);
            if (m_mode == M_CONFIRM) begin
                if (tc < 0) begin
                    m_mode = M_HUNT; m_tokens = 0;
                end else begin
                    m_tokens++;
                    if (m_tokens == LOCK_COUNT) begin
                        m_mode = M_LOCKED; m_gap = 0; m_errs = 0;
                        emit(w, tc);
                    end
                end
            end else begin
                drop = 0;
                if (tc >= 0) m_gap = 0;
                else begin
                    m_gap++;
                    if (m_gap >= GAP_LIMIT) drop = 1;
                end
`ifdef TMDS_DEC_ERR_EN
                if (tc < 0 && ref_bad(w)) begin
                    m_err = 1'b1;
                    m_errs++;
                    if (m_errs >= ERR_LIMIT) drop = 1;
                end else begin
                    m_errs = 0;
                end
`endif
                if (drop) begin
                    m_mode = M_HUNT; m_tokens = 0; m_gap = 0; m_errs = 0;
                end else begin
                    emit(w, tc);
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [9:0] raw, input logic valid);
        @(negedge clk_in);
        bus.raw_in       = raw;
        bus.raw_valid_in = valid;
        model_step(raw, valid);
        exp_q.push_back({m_valid, m_mode == M_LOCKED, m_ve, m_ctrl, m_data, m_err, 4'(m_rot)});
        @(posedge clk_in);
        #1;
        check("out", 32'(dut_vec()), 32'(exp_q.pop_front()));
    endtask

    // Serializer with the stream delayed by s bits relative to raw word boundaries.
    task automatic tx(input logic [9:0] w, input int s);
        logic [19:0] pair;
        pair   = {w, g_prev};
        g_prev = w;
        send(10'(pair >> (10 - s)), 1'b1);
    endtask

    task automatic do_reset();
        bus.raw_valid_in = 1'b0;
        @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_async_out", 32'(dut_vec()), 32'd0);
        check("rst_async_state", 32'(bus.state_dbg), 32'(ST_HUNT));
        repeat (3) begin
            @(negedge clk_in);
            bus.raw_in       = 10'($urandom);
            bus.raw_valid_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk_in);
        bus.raw_valid_in = 1'b0;
        rst_n_in         = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int s;
        bus.raw_in       = '0;
        bus.raw_valid_in = 1'b0;
        model_reset();
        g_prev = '0;
        #1;
        check("reset_out", 32'(dut_vec()), 32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'(ST_HUNT));
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        // Aligned token stream; rotation 0 lags by one word, so the 16th token lands on the 17th raw word.
        g_prev = 10'h354;
        repeat (LOCK_COUNT) tx(10'h354, 0);
        check("lock_not_yet", 32'(bus.locked_out), 32'd0);
        tx(10'h354, 0);
        check("lock_rot0", 32'(bus.locked_out), 32'd1);
        check("rot0", 32'(bus.rot_out), 32'd0);
        check("ctrl0", 32'(bus.control_out), 32'd0);
        check("ve0", 32'(bus.ve_out), 32'd0);

        tx(10'h2FF, 0);
        tx(10'h100, 0);
        check("data_2ff", 32'(bus.data_out), 32'h0FE);
        check("ctrl_hold", 32'(bus.control_out), 32'd0);
        check("ve_2ff", 32'(bus.ve_out), 32'd1);
        tx(10'h354, 0);
        check("data_100", 32'(bus.data_out), 32'h000);

        // Gap limit: the first of these words still delivers the pending token.
        for (int i = 0; i < GAP_LIMIT; i++) tx(10'h100, 0);
        check("gap_hold", 32'(bus.locked_out), 32'd1);
        tx(10'h100, 0);
        check("gap_drop_lock", 32'(bus.locked_out), 32'd0);
        check("gap_drop_valid", 32'(bus.valid_out), 32'd0);
        tx(10'h354, 0);
        tx(10'h354, 0);
        check("reconfirm", 32'(bus.state_dbg), 32'(ST_CONFIRM));

        // Relock then feed invalid data codes.
        repeat (LOCK_COUNT - 1) tx(10'h354, 0);
        check("relock", 32'(bus.locked_out), 32'd1);
        repeat (ERR_LIMIT) tx(10'h155, 0);
        tx(10'h354, 0);
`ifdef TMDS_DEC_ERR_EN
        check("err_drop_lock", 32'(bus.locked_out), 32'd0);
        check("err_pulse", 32'(bus.err_out), 32'd1);
`else
        check("err_hold_lock", 32'(bus.locked_out), 32'd1);
        check("err_quiet", 32'(bus.err_out), 32'd0);
`endif

        // Three-bit skew.
        do_reset();
        g_prev = 10'h354;
        repeat (LOCK_COUNT + 1) tx(10'h354, 3);
        check("lock_skew3", 32'(bus.locked_out), 32'd1);
        check("rot_skew3", 32'(bus.rot_out), 32'd3);
        tx(10'h100, 3);
        tx(10'h354, 3);
        check("skew_data", 32'(bus.data_out), 32'h000);
        check("skew_ve", 32'(bus.ve_out), 32'd1);

        // Reset in the middle of CONFIRM, then lock from scratch.
        do_reset();
        g_prev = 10'h354;
        repeat (6) tx(10'h354, 0);
        check("mid_confirm", 32'(bus.state_dbg), 32'(ST_CONFIRM));
        do_reset();
        repeat (LOCK_COUNT) tx(10'h354, 0);
        check("fresh_not_locked", 32'(bus.locked_out), 32'd0);
        tx(10'h354, 0);
        check("fresh_locked", 32'(bus.locked_out), 32'd1);

        // Randomized skewed streams.
        for (int round = 0; round < 6; round++) begin
            s = $urandom_range(0, 9);
            do_reset();
            g_prev = 10'($urandom);
            repeat (LOCK_COUNT + 4) tx(tok_tab[$urandom_range(0, 3)], s);
            for (int n = 0; n < 400; n++) begin
                k = $urandom_range(0, 99);
                if (k < 60)      tx(ref_encode(8'($urandom), 1'($urandom)), s);
                else if (k < 80) tx(tok_tab[$urandom_range(0, 3)], s);
                else if (k < 92) send(10'($urandom), 1'b0);
                else             tx(10'($urandom), s);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
